// File: rtl/shift_pkg.sv
// Shared shift-type encoding and parameter helpers for the shift pipeline.
// Imported by shift_core and shift_pipe.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    localparam int AMT_W = 8;

    function automatic logic width_ok(input int w);
        return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter with register/immediate amount decoding
// and shifter carry-out.
module shift_core
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [AMT_W-1:0] amt_i,
    input  shift_t           type_i,
    input  logic             imm_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] y_o,
    output logic             carry_o
);

    localparam int         LW = $clog2(WIDTH);
    localparam logic [8:0] WN = 9'(WIDTH);

    logic [8:0]       n;
    logic             rrx;
    logic [LW-1:0]    m;
    logic [LW-1:0]    k;
    logic [LW-1:0]    li;
    logic [LW-1:0]    ri;
    logic [LW:0]      rsh;
    logic [WIDTH-1:0] rot;

    assign m = amt_i[LW-1:0];

    // Immediate zero re-encodes LSR/ASR as a full-width shift and ROR as RRX.
    always_comb begin
        n   = {1'b0, amt_i};
        rrx = 1'b0;
        if (imm_i) begin
            n = {{(9-LW){1'b0}}, m};
            if (m == '0) begin
                unique case (type_i)
                    SH_LSR, SH_ASR: n = WN;
                    SH_ROR:         rrx = 1'b1;
                    default:        n = '0;
                endcase
            end
        end
    end

    // Carry bit indices, meaningful only for 0 < n < WIDTH.
    assign li  = LW'(WN - n);
    assign ri  = LW'(n - 9'd1);
    assign k   = n[LW-1:0];
    assign rsh = WN[LW:0] - {1'b0, k};
    assign rot = (a_i >> k) | (a_i << rsh);

    always_comb begin
        y_o     = a_i;
        carry_o = carry_i;
        if (rrx) begin
            y_o     = {carry_i, a_i[WIDTH-1:1]};
            carry_o = a_i[0];
        end else if (n != '0) begin
            unique case (type_i)
                SH_LSL: begin
                    if (n < WN) begin
                        y_o     = a_i << n;
                        carry_o = a_i[li];
                    end else begin
                        y_o     = '0;
                        carry_o = (n == WN) & a_i[0];
                    end
                end
                SH_LSR: begin
                    if (n < WN) begin
                        y_o     = a_i >> n;
                        carry_o = a_i[ri];
                    end else begin
                        y_o     = '0;
                        carry_o = (n == WN) & a_i[WIDTH-1];
                    end
                end
                SH_ASR: begin
                    if (n < WN) begin
                        y_o     = $unsigned($signed(a_i) >>> n);
                        carry_o = a_i[ri];
                    end else begin
                        y_o     = {WIDTH{a_i[WIDTH-1]}};
                        carry_o = a_i[WIDTH-1];
                    end
                end
                SH_ROR: begin
                    if (k == '0) begin
                        y_o     = a_i;
                        carry_o = a_i[WIDTH-1];
                    end else begin
                        y_o     = rot;
                        carry_o = rot[WIDTH-1];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Valid/ready pipelined wrapper around shift_core: one or two register
// stages, one result per cycle, backpressure from out_ready.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [7:0]       in_amt,
    input  logic [1:0]       in_type,
    input  logic             in_imm,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("shift_pipe: WIDTH must be a power of two in 8..64");
    end
    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("shift_pipe: STAGES must be 1 or 2");
    end

    logic [WIDTH-1:0] c_a;
    logic [WIDTH-1:0] c_y;
    logic [7:0]       c_amt;
    logic [1:0]       c_type;
    logic             c_imm;
    logic             c_cin;
    logic             c_cout;
    logic             load_o;

    logic             o_v_q, o_v_d;
    logic [WIDTH-1:0] o_y_q, o_y_d;
    logic             o_c_q, o_c_d;

    shift_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (c_a),
        .amt_i   (c_amt),
        .type_i  (shift_t'(c_type)),
        .imm_i   (c_imm),
        .carry_i (c_cin),
        .y_o     (c_y),
        .carry_o (c_cout)
    );

    if (STAGES == 2) begin : g_s2
        logic             s1_v_q, s1_v_d;
        logic             load1;
        logic [WIDTH-1:0] s1_a_q;
        logic [7:0]       s1_amt_q;
        logic [1:0]       s1_type_q;
        logic             s1_imm_q;
        logic             s1_c_q;

        assign load_o   = s1_v_q & (~o_v_q | out_ready);
        assign in_ready = ~reset & (~s1_v_q | load_o);
        assign load1    = in_valid & in_ready;
        assign s1_v_d   = load1 | (s1_v_q & ~load_o);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_v_q    <= 1'b0;
                s1_a_q    <= '0;
                s1_amt_q  <= '0;
                s1_type_q <= '0;
                s1_imm_q  <= 1'b0;
                s1_c_q    <= 1'b0;
            end else begin
                s1_v_q <= s1_v_d;
                if (load1) begin
                    s1_a_q    <= in_a;
                    s1_amt_q  <= in_amt;
                    s1_type_q <= in_type;
                    s1_imm_q  <= in_imm;
                    s1_c_q    <= in_carry;
                end
            end
        end

        assign c_a    = s1_a_q;
        assign c_amt  = s1_amt_q;
        assign c_type = s1_type_q;
        assign c_imm  = s1_imm_q;
        assign c_cin  = s1_c_q;
    end else begin : g_s1
        assign in_ready = ~reset & (~o_v_q | out_ready);
        assign load_o   = in_valid & in_ready;
        assign c_a      = in_a;
        assign c_amt    = in_amt;
        assign c_type   = in_type;
        assign c_imm    = in_imm;
        assign c_cin    = in_carry;
    end

    always_comb begin
        o_v_d = load_o | (o_v_q & ~out_ready);
        o_y_d = o_y_q;
        o_c_d = o_c_q;
        if (load_o) begin
            o_y_d = c_y;
            o_c_d = c_cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_v_q <= 1'b0;
            o_y_q <= '0;
            o_c_q <= 1'b0;
        end else begin
            o_v_q <= o_v_d;
            o_y_q <= o_y_d;
            o_c_q <= o_c_d;
        end
    end

    // Result lanes read zero whenever no result is presented.
    assign out_valid = o_v_q;
    assign out_y     = o_v_q ? o_y_q : '0;
    assign out_carry = o_v_q & o_c_q;

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; power of two, 8..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_a  input  WIDTH  operand to shift.
REQ-008 SHALL have port in_amt  input  8  shift amount (Rs bottom byte or immediate).
REQ-009 SHALL have port in_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-010 SHALL have port in_imm  input  1  1 = immediate encoding, 0 = register encoding.
REQ-011 SHALL have port in_carry  input  1  current C flag.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port out_y  output  WIDTH  shifted result.
REQ-015 SHALL have port out_carry  output  1  shifter carry-out.

Function
REQ-016 Register form (in_imm=0) SHALL use all 8 bits of in_amt; let n = in_amt and W = WIDTH.
REQ-017 n=0, any type: y=a, carry=in_carry.
REQ-018 LSL: 1..W-1 -> y=a<<n, carry=a[W-n]; n=W -> y=0, carry=a[0]; n>W -> y=0, carry=0.
REQ-019 LSR: 1..W-1 -> y=a>>n, carry=a[n-1]; n=W -> y=0, carry=a[W-1]; n>W -> y=0, carry=0.
REQ-020 ASR: 1..W-1 -> arithmetic shift, carry=a[n-1]; n>=W -> y = all bits a[W-1], carry=a[W-1].
REQ-021 ROR: k = n mod W; k=0 with n!=0 -> y=a, carry=a[W-1]; otherwise y = a rotated right by k, carry=y[W-1].
REQ-022 Immediate form (in_imm=1) SHALL use only in_amt[log2(W)-1:0] = m; m!=0 -> same results as register form with n=m.
REQ-023 Immediate form, m=0: LSL -> y=a, carry=in_carry; LSR -> treated as n=W; ASR -> treated as n=W; ROR -> RRX: y={in_carry, a[W-1:1]}, carry=a[0].
REQ-024 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no backpressure is applied.
REQ-025 STAGES=2: stage 1 registers the decoded effective amount, type class, and operands; stage 2 registers the result.
REQ-026 Each stage SHALL hold a valid bit; a stage loads when it is empty or the downstream stage advances in the same cycle.
REQ-027 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing); it is combinational from out_ready through the stage chain; throughput is 1 result per cycle.
REQ-028 While out_valid=1 and out_ready=0, out_y, out_carry and out_valid SHALL remain stable and no accepted request SHALL be dropped or duplicated.
REQ-029 When the pipeline is full and out_ready=1 coincides with a new in_valid, the request SHALL be accepted and every stage SHALL advance in the same cycle.
REQ-030 in_* SHALL be ignored when in_valid=0; the data registers of empty stages are don't-care, but out_y/out_carry SHALL read 0 while out_valid=0.

Reset
REQ-031 Asserting reset SHALL immediately clear all stage valid bits; the effect is asynchronous.
REQ-032 During reset: out_valid=0, out_y=0, out_carry=0, in_ready=0.
REQ-033 Requests in flight when reset asserts SHALL be discarded.
REQ-034 in_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-035 A shared package shift_pkg SHALL hold the shift-type constants (LSL, LSR, ASR, ROR) and the 2-bit type typedef; the rest of the pipeline imports it.
REQ-036 The combinational semantics of REQ-016..023 SHALL live in one sub-module, shift_core, parametrised by WIDTH; shift_pipe adds the stage registers and handshake only.
REQ-037 Out-of-range parameters SHALL cause an elaboration-time error.

Verification
REQ-038 W=32, register form, LSL: a=0x80000001, n=1 -> y=0x00000002, c=1; n=32 -> y=0, c=1; n=33 -> y=0, c=0.
REQ-039 Immediate form, ASR, m=0: a=0x80000000 -> y=0xFFFFFFFF, c=1; immediate ROR m=0 with in_carry=1, a=0x00000003 -> y=0x80000001, c=1.
REQ-040 Register form, ROR: n=36, a=0x0000000F -> y=0xF0000000, c=1; n=64 -> y=a, c=a[31].
REQ-041 STAGES=2: stream 8 back-to-back requests with out_ready held high -> first out_valid 2 cycles after acceptance, then 8 consecutive results in order.
REQ-042 Hold out_ready=0 for 5 cycles with a full pipeline -> in_ready=0, outputs stable; release -> no loss or duplication; assert reset mid-stream -> out_valid=0 at once, in_ready=1 one cycle after release.
REQ-043 Repeat REQ-038..042 with WIDTH=16 and WIDTH=64, and with STAGES=1 (latency 1).
